// File: rtl/pic_pkg.sv
// pic_pkg: shared widths and cascade role encoding for the 8259A-compatible PIC
package pic_pkg;
  localparam int ID_W = 3;
  localparam int ICW3_W = 8;
  typedef enum logic [1:0] {ROLE_SINGLE, ROLE_MASTER, ROLE_SLAVE} role_t;
endpackage

// File: rtl/cascade_mode_decode.sv
// cascade_mode_decode: resolves single/master/slave role from ICW1.SNGL, ICW4.BUF, ICW4.M/S and the SP/EN pin
module cascade_mode_decode import pic_pkg::*; (
  input  logic  single_or_cascade_config,
  input  logic  buffered_mode_config,
  input  logic  buffered_master_or_slave_config,
  input  logic  slave_program,
  output role_t role,
  output logic  cascade_slave,
  output logic  cascade_io
);
  logic is_master;
  always_comb begin
    is_master = buffered_mode_config ? buffered_master_or_slave_config : slave_program;
    role = single_or_cascade_config ? ROLE_SINGLE : (is_master ? ROLE_MASTER : ROLE_SLAVE);
    cascade_slave = (role == ROLE_SLAVE);
    cascade_io = (role == ROLE_MASTER);
  end
endmodule

// File: rtl/cascade_signals.sv
// cascade_signals: cascade-bus controller; drives or matches CAS2..0 and decides who supplies the INTA 2/3 vector
// Ports: clock/reset (async active-high), ICW/SP config inputs, cascade_id (CAS pins in), acknowledge_level,
//   acknowledge_interrupt (first INTA strobe), control_state (INTA 2/3 in progress); outputs role flags,
//   cascade_slave_enable, interrupt_from_slave_device, cascade_output_ack_2_3, cascade_out (CAS pins out).
// Build option: define CASCADE_ACK_LATCH_EN to latch CAS/slave-enable at the first INTA strobe;
//   otherwise everything is combinational with zero latency.
module cascade_signals import pic_pkg::*; (
  input  logic              clock,
  input  logic              reset,
  input  logic              single_or_cascade_config,
  input  logic              buffered_mode_config,
  input  logic              buffered_master_or_slave_config,
  input  logic              slave_program,
  input  logic [ICW3_W-1:0] cascade_device_config,
  input  logic [ID_W-1:0]   cascade_id,
  input  logic [ID_W-1:0]   acknowledge_level,
  input  logic              acknowledge_interrupt,
  input  logic              control_state,
  output logic              cascade_slave,
  output logic              cascade_io,
  output logic              cascade_slave_enable,
  output logic              interrupt_from_slave_device,
  output logic              cascade_output_ack_2_3,
  output logic [ID_W-1:0]   cascade_out
);
  role_t role;
  logic id_match;
  cascade_mode_decode u_decode (
    .single_or_cascade_config        (single_or_cascade_config),
    .buffered_mode_config            (buffered_mode_config),
    .buffered_master_or_slave_config (buffered_master_or_slave_config),
    .slave_program                   (slave_program),
    .role                            (role),
    .cascade_slave                   (cascade_slave),
    .cascade_io                      (cascade_io)
  );
  assign interrupt_from_slave_device = cascade_io & cascade_device_config[acknowledge_level];
  assign id_match = (cascade_id == cascade_device_config[ID_W-1:0]);
`ifdef CASCADE_ACK_LATCH_EN
  role_t role_q;
  logic [ID_W-1:0] out_q;
  logic slave_en_q;
  logic from_slave_q;
  // A role change discards any sequence state latched under the previous role.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      role_q <= ROLE_SINGLE;
      out_q <= '0;
      slave_en_q <= 1'b0;
      from_slave_q <= 1'b0;
    end else if (role != role_q) begin
      role_q <= role;
      out_q <= '0;
      slave_en_q <= 1'b0;
      from_slave_q <= 1'b0;
    end else if (acknowledge_interrupt && !control_state) begin
      out_q <= interrupt_from_slave_device ? acknowledge_level : '0;
      slave_en_q <= cascade_slave & id_match;
      from_slave_q <= interrupt_from_slave_device;
    end else if (!control_state) begin
      out_q <= '0;
      slave_en_q <= 1'b0;
      from_slave_q <= 1'b0;
    end
  end
  always_comb begin
    cascade_out = cascade_io ? out_q : '0;
    cascade_slave_enable = cascade_slave & slave_en_q;
    cascade_output_ack_2_3 = (role == ROLE_SINGLE) ? 1'b1 :
                             (role == ROLE_MASTER) ? ~from_slave_q : cascade_slave_enable;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clock & reset;
  always_comb begin
    cascade_out = (interrupt_from_slave_device & (acknowledge_interrupt | control_state)) ? acknowledge_level : '0;
    cascade_slave_enable = cascade_slave & id_match;
    cascade_output_ack_2_3 = (role == ROLE_SINGLE) ? 1'b1 :
                             (role == ROLE_MASTER) ? ~interrupt_from_slave_device : cascade_slave_enable;
  end
`endif
endmodule

// File: tb/tb_cascade_signals.sv
// tb_cascade_signals: directed vectors with a scoreboard queue checked by a separate negedge monitor
module tb_cascade_signals;
`ifdef CASCADE_ACK_LATCH_EN
  localparam bit L = 1'b1;
`else
  localparam bit L = 1'b0;
`endif
  typedef struct {
    string name;
    logic slave;
    logic io;
    logic en;
    logic fs;
    logic ack;
    logic [2:0] out;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic single = 1'b0, buffered = 1'b0, ms = 1'b0, sp = 1'b1;
  logic [7:0] icw3 = 8'h00;
  logic [2:0] cas_id = 3'd7, level = 3'd0;
  logic strobe = 1'b0, cs = 1'b0;
  logic cascade_slave, cascade_io, cascade_slave_enable, interrupt_from_slave_device, cascade_output_ack_2_3;
  logic [2:0] cascade_out;
  exp_t q[$];
  int n_vec = 0;
  int n_miss = 0;
  always #5 clock = ~clock;
  cascade_signals dut (
    .clock                           (clock),
    .reset                           (reset),
    .single_or_cascade_config        (single),
    .buffered_mode_config            (buffered),
    .buffered_master_or_slave_config (ms),
    .slave_program                   (sp),
    .cascade_device_config           (icw3),
    .cascade_id                      (cas_id),
    .acknowledge_level               (level),
    .acknowledge_interrupt           (strobe),
    .control_state                   (cs),
    .cascade_slave                   (cascade_slave),
    .cascade_io                      (cascade_io),
    .cascade_slave_enable            (cascade_slave_enable),
    .interrupt_from_slave_device     (interrupt_from_slave_device),
    .cascade_output_ack_2_3          (cascade_output_ack_2_3),
    .cascade_out                     (cascade_out)
  );
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic vec(input string n, input logic s, input logic io, input logic en, input logic fs,
                     input logic ack, input logic [2:0] out);
    exp_t e;
    e.name = n; e.slave = s; e.io = io; e.en = en; e.fs = fs; e.ack = ack; e.out = out;
    q.push_back(e);
  endtask
  task automatic chk(input string n, input string f, input logic [2:0] got, input logic [2:0] want);
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s.%s got %0d want %0d", n, f, got, want);
    end
  endtask
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      chk(e.name, "slave", {2'b0, cascade_slave}, {2'b0, e.slave});
      chk(e.name, "io", {2'b0, cascade_io}, {2'b0, e.io});
      chk(e.name, "slave_en", {2'b0, cascade_slave_enable}, {2'b0, e.en});
      chk(e.name, "from_slave", {2'b0, interrupt_from_slave_device}, {2'b0, e.fs});
      chk(e.name, "ack_2_3", {2'b0, cascade_output_ack_2_3}, {2'b0, e.ack});
      chk(e.name, "cas_out", cascade_out, e.out);
    end
  end
  initial begin
    tick; vec("reset", 0, 1, 0, 0, 1, 0);
    tick; reset = 0; vec("idle_master", 0, 1, 0, 0, 1, 0);
    tick; sp = 0; vec("slave_role", 1, 0, 0, 0, 0, 0);
    tick; buffered = 1; ms = 1; vec("buf_master", 0, 1, 0, 0, 1, 0);
    tick; single = 1; vec("single", 0, 0, 0, 0, 1, 0);
    tick; single = 0; buffered = 0; ms = 0; sp = 1; icw3 = 8'h04; level = 3'd2;
    vec("m_setup", 0, 1, 0, 1, L ? 1'b1 : 1'b0, 0);
    tick; strobe = 1; vec("m_strobe", 0, 1, 0, 1, L ? 1'b1 : 1'b0, L ? 3'd0 : 3'd2);
    tick; strobe = 0; cs = 1; vec("m_seq", 0, 1, 0, 1, 0, 2);
    tick; level = 3'd3; vec("m_hold", 0, 1, 0, 0, L ? 1'b0 : 1'b1, L ? 3'd2 : 3'd0);
    tick; cs = 0; vec("m_end", 0, 1, 0, 0, L ? 1'b0 : 1'b1, L ? 3'd2 : 3'd0);
    tick; vec("m_clear", 0, 1, 0, 0, 1, 0);
    tick; strobe = 1; vec("m3_strobe", 0, 1, 0, 0, 1, 0);
    tick; strobe = 0; cs = 1; vec("m3_seq", 0, 1, 0, 0, 1, 0);
    tick; cs = 0; vec("m3_end", 0, 1, 0, 0, 1, 0);
    tick; sp = 0; icw3 = 8'h05; cas_id = 3'd5; level = 3'd0;
    vec("s_setup", 1, 0, L ? 1'b0 : 1'b1, 0, L ? 1'b0 : 1'b1, 0);
    tick; strobe = 1; vec("s_strobe", 1, 0, L ? 1'b0 : 1'b1, 0, L ? 1'b0 : 1'b1, 0);
    tick; strobe = 0; cs = 1; cas_id = 3'd4; vec("s_seq", 1, 0, L, 0, L, 0);
    tick; cs = 0; vec("s_end", 1, 0, L, 0, L, 0);
    tick; vec("s_clear", 1, 0, 0, 0, 0, 0);
    tick; strobe = 1; vec("s4_strobe", 1, 0, 0, 0, 0, 0);
    tick; strobe = 0; cs = 1; vec("s4_seq", 1, 0, 0, 0, 0, 0);
    tick; cs = 0; vec("s4_end", 1, 0, 0, 0, 0, 0);
    tick; sp = 1; icw3 = 8'h04; level = 3'd2; cas_id = 3'd7;
    vec("r_setup", 0, 1, 0, 1, L ? 1'b1 : 1'b0, 0);
    tick; strobe = 1; vec("r_strobe", 0, 1, 0, 1, L ? 1'b1 : 1'b0, L ? 3'd0 : 3'd2);
    tick; strobe = 0; cs = 1; vec("r_seq", 0, 1, 0, 1, 0, 2);
    tick; strobe = 1; level = 3'd3; vec("r_restrobe", 0, 1, 0, 0, L ? 1'b0 : 1'b1, L ? 3'd2 : 3'd0);
    tick; strobe = 0; level = 3'd2; reset = 1; vec("r_async", 0, 1, 0, 1, L ? 1'b1 : 1'b0, L ? 3'd0 : 3'd2);
    tick; reset = 0; cs = 0; vec("r_release", 0, 1, 0, 1, L ? 1'b1 : 1'b0, 0);
    repeat (3) @(posedge clock);
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
